// File: rtl/ram_arb_rr.sv
// ram_arb_rr: N-port arbiter (round-robin or fixed priority) in front of one single-ported synchronous RAM.
// Latency: grant and RAM drive are combinational; port_rvalid_o returns exactly RAM_LATENCY cycles after the grant.
// Backpressure: a requester holds req and fields until granted; the response pipeline takes one grant per cycle, never stalls.
//
// Ports:
//   clk, rst_n        : rising-edge clock, synchronous active-low reset
//   port_*            : per-master request/grant/response buses, port p at slice p
//   ram_*             : single-ported RAM macro interface (byte address, lane-steered be/wdata)
//   stall_cnt_o       : 16-bit saturating stall counter per port
// Optional feature macro: RAM_ARB_STALL_CNT_EN (stall counters; undefined -> stall_cnt_o tied to 0).
module ram_arb_rr #(
  parameter int NUM_PORTS   = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int OUT_WIDTH   = 32,
  parameter int IN_WIDTH    = 32,
  parameter int RAM_LATENCY = 1,
  parameter int ARB_MODE    = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_PORTS-1:0]              port_req_i,
  output logic [NUM_PORTS-1:0]              port_gnt_o,
  output logic [NUM_PORTS-1:0]              port_rvalid_o,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   port_addr_i,
  input  logic [NUM_PORTS-1:0]              port_we_i,
  input  logic [NUM_PORTS*IN_WIDTH/8-1:0]   port_be_i,
  input  logic [NUM_PORTS*IN_WIDTH-1:0]     port_wdata_i,
  output logic [NUM_PORTS*IN_WIDTH-1:0]     port_rdata_o,
  output logic                              ram_en_o,
  output logic [ADDR_WIDTH-1:0]             ram_addr_o,
  output logic                              ram_we_o,
  output logic [OUT_WIDTH/8-1:0]            ram_be_o,
  output logic [OUT_WIDTH-1:0]              ram_wdata_o,
  input  logic [OUT_WIDTH-1:0]              ram_rdata_i,
  output logic [NUM_PORTS*16-1:0]           stall_cnt_o
);

  localparam int BE_IN   = IN_WIDTH / 8;
  localparam int BE_OUT  = OUT_WIDTH / 8;
  localparam int RATIO   = OUT_WIDTH / IN_WIDTH;
  localparam int LANE_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int LANE_LO = $clog2(BE_IN);
  localparam int ID_W    = $clog2(NUM_PORTS);
  localparam int LAST    = RAM_LATENCY - 1;

  // ---------------------------------------------------------------- arbitration
  logic [ID_W-1:0]      r_rr;
  logic [NUM_PORTS-1:0] w_gnt;
  logic [ID_W-1:0]      w_gnt_id;
  logic                 w_gnt_any;
  logic [ID_W:0]        w_scan;

  // Scan from r_rr (round robin) or from 0 (fixed priority); first requester wins.
  always_comb begin
    w_gnt     = '0;
    w_gnt_id  = '0;
    w_gnt_any = 1'b0;
    w_scan    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (ARB_MODE == 0) begin
        w_scan = (ID_W+1)'(i);
      end else begin
        w_scan = {1'b0, r_rr} + (ID_W+1)'(i);
        if (w_scan >= (ID_W+1)'(NUM_PORTS)) w_scan = w_scan - (ID_W+1)'(NUM_PORTS);
      end
      if (!w_gnt_any && port_req_i[w_scan[ID_W-1:0]]) begin
        w_gnt_any                  = 1'b1;
        w_gnt_id                   = w_scan[ID_W-1:0];
        w_gnt[w_scan[ID_W-1:0]]    = 1'b1;
      end
    end
  end

  assign port_gnt_o = w_gnt;
  assign ram_en_o   = |port_req_i;

  // Pointer moves to the port after the winner; holds when nobody is granted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr <= '0;
    end else if (ARB_MODE != 0 && w_gnt_any) begin
      r_rr <= (w_gnt_id == ID_W'(NUM_PORTS - 1)) ? '0 : w_gnt_id + ID_W'(1);
    end
  end

  // ---------------------------------------------------------------- RAM drive
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_we;
  logic [BE_IN-1:0]      w_be;
  logic [IN_WIDTH-1:0]   w_wdata;
  logic [LANE_W-1:0]     w_lane;

  // One-hot mux; all fields are zero when nothing is granted.
  always_comb begin
    w_addr  = '0;
    w_we    = 1'b0;
    w_be    = '0;
    w_wdata = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_gnt[p]) begin
        w_addr  = port_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
        w_we    = port_we_i[p];
        w_be    = port_be_i[p*BE_IN +: BE_IN];
        w_wdata = port_wdata_i[p*IN_WIDTH +: IN_WIDTH];
      end
    end
  end

  generate
    if (RATIO > 1) begin : g_lane
      assign w_lane = w_addr[LANE_LO +: LANE_W];
    end else begin : g_nolane
      assign w_lane = '0;
    end
  endgenerate

  assign ram_addr_o  = w_addr;
  assign ram_we_o    = w_we;
  assign ram_be_o    = BE_OUT'(w_be) << (w_lane * BE_IN);
  // Narrow write data is replicated across the word; byte enables pick the lane.
  assign ram_wdata_o = {RATIO{w_wdata}};

  // ---------------------------------------------------------------- response pipeline
  logic [RAM_LATENCY-1:0] r_vld;
  logic [ID_W-1:0]        r_id      [RAM_LATENCY];
  logic [LANE_W-1:0]      r_pl_lane [RAM_LATENCY];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int s = 0; s < RAM_LATENCY; s++) begin
        r_id[s]      <= '0;
        r_pl_lane[s] <= '0;
      end
    end else begin
      r_vld[0]     <= w_gnt_any;
      r_id[0]      <= w_gnt_id;
      r_pl_lane[0] <= w_lane;
      for (int s = 1; s < RAM_LATENCY; s++) begin
        r_vld[s]     <= r_vld[s-1];
        r_id[s]      <= r_id[s-1];
        r_pl_lane[s] <= r_pl_lane[s-1];
      end
    end
  end

  logic [NUM_PORTS-1:0] w_rvalid;

  always_comb begin
    w_rvalid = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_rvalid[p] = r_vld[LAST] && (r_id[LAST] == ID_W'(p));
    end
  end

  assign port_rvalid_o = w_rvalid;

  // ---------------------------------------------------------------- read data
  logic [LANE_W-1:0] r_port_lane [NUM_PORTS];
  logic [LANE_W-1:0] w_sel_lane  [NUM_PORTS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PORTS; p++) r_port_lane[p] <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_rvalid[p]) r_port_lane[p] <= r_pl_lane[LAST];
      end
    end
  end

  // The register only catches up at the end of the rvalid cycle, so the
  // delivering cycle takes its lane straight from the last pipeline stage.
  always_comb begin
    port_rdata_o = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_sel_lane[p] = w_rvalid[p] ? r_pl_lane[LAST] : r_port_lane[p];
      for (int l = 0; l < RATIO; l++) begin
        if (w_sel_lane[p] == LANE_W'(l)) begin
          port_rdata_o[p*IN_WIDTH +: IN_WIDTH] = ram_rdata_i[l*IN_WIDTH +: IN_WIDTH];
        end
      end
    end
  end

  // ---------------------------------------------------------------- stall counters
`ifdef RAM_ARB_STALL_CNT_EN
  logic [15:0] r_stall [NUM_PORTS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PORTS; p++) r_stall[p] <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (port_req_i[p] && !w_gnt[p] && (r_stall[p] != 16'hFFFF)) begin
          r_stall[p] <= r_stall[p] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    stall_cnt_o = '0;
    for (int p = 0; p < NUM_PORTS; p++) stall_cnt_o[p*16 +: 16] = r_stall[p];
  end
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ram_arb_rr.sv
// tb_ram_arb_rr: directed checks of two arbiter configurations sharing one clock and reset.
// u_rr: 4 ports, 32/32 bit, latency 2, round robin. u_fp: 4 ports, 8-bit ports on 32-bit RAM, latency 3, fixed priority.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_ram_arb_rr;

`ifdef RAM_ARB_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // u_rr signals
  logic [3:0]   a_req, a_gnt, a_rvalid, a_we;
  logic [127:0] a_addr, a_wdata, a_rdata;
  logic [15:0]  a_be;
  logic         a_en, a_rwe;
  logic [31:0]  a_raddr, a_rwdata, a_rrdata;
  logic [3:0]   a_rbe;
  logic [63:0]  a_stall;

  // u_fp signals
  logic [3:0]   b_req, b_gnt, b_rvalid, b_we, b_be;
  logic [127:0] b_addr;
  logic [31:0]  b_wdata, b_rdata;
  logic         b_en, b_rwe;
  logic [31:0]  b_raddr, b_rwdata, b_rrdata;
  logic [3:0]   b_rbe;
  logic [63:0]  b_stall;

  ram_arb_rr #(.NUM_PORTS(4), .ADDR_WIDTH(32), .OUT_WIDTH(32), .IN_WIDTH(32),
               .RAM_LATENCY(2), .ARB_MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .port_req_i(a_req), .port_gnt_o(a_gnt), .port_rvalid_o(a_rvalid),
    .port_addr_i(a_addr), .port_we_i(a_we), .port_be_i(a_be),
    .port_wdata_i(a_wdata), .port_rdata_o(a_rdata),
    .ram_en_o(a_en), .ram_addr_o(a_raddr), .ram_we_o(a_rwe), .ram_be_o(a_rbe),
    .ram_wdata_o(a_rwdata), .ram_rdata_i(a_rrdata), .stall_cnt_o(a_stall)
  );

  ram_arb_rr #(.NUM_PORTS(4), .ADDR_WIDTH(32), .OUT_WIDTH(32), .IN_WIDTH(8),
               .RAM_LATENCY(3), .ARB_MODE(0)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .port_req_i(b_req), .port_gnt_o(b_gnt), .port_rvalid_o(b_rvalid),
    .port_addr_i(b_addr), .port_we_i(b_we), .port_be_i(b_be),
    .port_wdata_i(b_wdata), .port_rdata_o(b_rdata),
    .ram_en_o(b_en), .ram_addr_o(b_raddr), .ram_we_o(b_rwe), .ram_be_o(b_rbe),
    .ram_wdata_o(b_rwdata), .ram_rdata_i(b_rrdata), .stall_cnt_o(b_stall)
  );

  int n_asrt = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_asrt++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  exp4;
    logic [31:0] exp32;
    int          sat_cyc;

    rst_n = 1'b0;
    a_req = '0; a_we = '0; a_be = '0; a_wdata = '0; a_rrdata = '0;
    b_req = '0; b_we = '0; b_be = '0; b_wdata = '0; b_rrdata = '0;
    for (int p = 0; p < 4; p++) a_addr[p*32 +: 32] = 32'h1000 + 32'(p*4);
    b_addr = '0;
    repeat (3) tick();

    // reset state
    #1;
    chk("rst_a_rvalid", a_rvalid, 4'h0);
    chk("rst_a_gnt", a_gnt, 4'h0);
    chk("rst_a_en", a_en, 1'b0);
    chk("rst_b_rvalid", b_rvalid, 4'h0);
    chk("rst_b_stall", b_stall, 64'h0);
    rst_n = 1'b1;

    // round robin, all four ports requesting for 8 cycles; rvalid 2 cycles after each grant
    for (int c = 0; c < 10; c++) begin
      a_req = (c < 8) ? 4'hF : 4'h0;
      #1;
      exp4 = (c < 8) ? (4'b0001 << (c % 4)) : 4'h0;
      chk("rr_gnt", a_gnt, exp4);
      chk("rr_en", a_en, (c < 8) ? 1'b1 : 1'b0);
      exp32 = (c < 8) ? 32'h1000 + 32'((c % 4) * 4) : 32'h0;
      chk("rr_addr", a_raddr, exp32);
      exp4 = (c >= 2) ? (4'b0001 << ((c - 2) % 4)) : 4'h0;
      chk("rr_rvalid", a_rvalid, exp4);
      tick();
    end
    // each port waited 6 of the 8 requesting cycles
    chk("rr_stall0", a_stall[15:0], STALL_EN ? 64'd6 : 64'd0);
    chk("rr_stall3", a_stall[63:48], STALL_EN ? 64'd6 : 64'd0);

    // fixed priority: ports 1 and 2 for 3 cycles, port 1 always wins
    for (int c = 0; c < 7; c++) begin
      b_req = (c < 3) ? 4'b0110 : 4'b0000;
      #1;
      chk("fp_gnt", b_gnt, (c < 3) ? 4'b0010 : 4'b0000);
      chk("fp_rvalid", b_rvalid, (c >= 3 && c < 6) ? 4'b0010 : 4'b0000);
      tick();
    end
    chk("fp_stall2", b_stall[47:32], STALL_EN ? 64'd3 : 64'd0);
    chk("fp_stall1", b_stall[31:16], 64'd0);

    // lane-steered byte write: 0xA5 to 0x102 lands in byte 2
    b_req = 4'b0001; b_we = 4'b0001; b_be = 4'b0001;
    b_wdata[7:0] = 8'hA5; b_addr[31:0] = 32'h102;
    #1;
    chk("wr_gnt", b_gnt, 4'b0001);
    chk("wr_we", b_rwe, 1'b1);
    chk("wr_be", b_rbe, 4'b0100);
    chk("wr_wdata", b_rwdata, 32'hA5A5A5A5);
    chk("wr_addr", b_raddr, 32'h102);
    tick();
    // read byte 3 back-to-back
    b_we = 4'b0000; b_addr[31:0] = 32'h103;
    #1;
    chk("rd_be", b_rbe, 4'b1000);
    chk("rd_we", b_rwe, 1'b0);
    tick();
    b_req = 4'b0000;
    #1;
    chk("idle_en", b_en, 1'b0);
    chk("idle_addr", b_raddr, 32'h0);
    chk("idle_wdata", b_rwdata, 32'h0);
    chk("idle_be", b_rbe, 4'h0);
    tick();
    #1;
    chk("wr_rvalid", b_rvalid, 4'b0001);
    tick();
    b_rrdata = 32'h11223344;
    #1;
    chk("rd_rvalid", b_rvalid, 4'b0001);
    chk("rd_lane3", b_rdata[7:0], 8'h11);
    tick();
    #1;
    chk("rd_done", b_rvalid, 4'b0000);

    // read byte 1
    b_req = 4'b0001; b_addr[31:0] = 32'h101;
    tick();
    b_req = 4'b0000;
    tick();
    tick();
    b_rrdata = 32'h11223344;
    #1;
    chk("rd1_rvalid", b_rvalid, 4'b0001);
    chk("rd_lane1", b_rdata[7:0], 8'h33);
    tick();

    // latency 3: port 2 at cycle 0, port 3 at cycle 1
    b_addr[64 +: 32] = 32'h200;
    b_addr[96 +: 32] = 32'h202;
    b_rrdata = 32'hDEADBEEF;
    for (int c = 0; c < 6; c++) begin
      b_req = (c == 0) ? 4'b0100 : (c == 1) ? 4'b1000 : 4'b0000;
      #1;
      exp4 = (c == 3) ? 4'b0100 : (c == 4) ? 4'b1000 : 4'b0000;
      chk("lat3_rvalid", b_rvalid, exp4);
      if (c == 3) chk("lat3_rdata2", b_rdata[23:16], 8'hEF);
      if (c == 4) chk("lat3_rdata3", b_rdata[31:24], 8'hAD);
      tick();
    end

    // stall counter saturation: port 1 starved by port 0
    sat_cyc = STALL_EN ? 70000 : 20;
    b_req = 4'b0011;
    #1;
    chk("sat_gnt", b_gnt, 4'b0001);
    repeat (sat_cyc) tick();
    chk("sat_cnt", b_stall[31:16], STALL_EN ? 64'hFFFF : 64'h0);
    repeat (3) tick();
    chk("sat_hold", b_stall[31:16], STALL_EN ? 64'hFFFF : 64'h0);
    chk("sat_port0", b_stall[15:0], 64'h0);
    b_req = 4'b0000;
    tick();

    // reset right after a grant: no rvalid for it, pointer back to 0
    a_req = 4'b0001;
    #1;
    chk("rst_pre_gnt", a_gnt, 4'b0001);
    tick();
    a_req = 4'b0000;
    rst_n = 1'b0;
    #1;
    chk("rst_cyc_rvalid", a_rvalid, 4'h0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_drop_rvalid", a_rvalid, 4'h0);
    chk("rst_stall_clr", b_stall, 64'h0);
    a_req = 4'b0011;
    #1;
    chk("rst_rr_gnt", a_gnt, 4'b0001);
    tick();
    a_req = 4'b0000;
    #1;
    chk("rst_post1_rvalid", a_rvalid, 4'h0);
    tick();
    #1;
    chk("rst_post2_rvalid", a_rvalid, 4'b0001);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arb_rr.md
Name: ram_arb_rr

Overview:
- N-port memory arbiter in front of a single-ported synchronous RAM.
- Successor to the two-port fixed-priority mux. Adds:
  - parametrised port count
  - round-robin or fixed-priority arbitration
  - configurable RAM read latency, with a response pipeline that tags each grant with its port and byte lane
- Sits between core/debug/DMA masters and one shared data RAM macro.
- Narrow ports are lane-steered onto the wide RAM word.

Parameters:
NUM_PORTS, 4, number of requesting ports (2..8)
ADDR_WIDTH, 32, byte address width
OUT_WIDTH, 32, RAM data width (32 or 64)
IN_WIDTH, 32, data width of every port (8, 16 or 32; must be ≤ OUT_WIDTH)
RAM_LATENCY, 1, cycles from ram_en_o to valid ram_rdata_i (1..4)
ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round robin

Ports:
clk  in  1  clock, all logic rising-edge
rst_n  in  1  reset, synchronous, active-low
port_req_i  in  NUM_PORTS  request per port
port_gnt_o  out  NUM_PORTS  grant per port, combinational, one-hot or zero
port_rvalid_o  out  NUM_PORTS  response valid per port
port_addr_i  in  NUM_PORTS*ADDR_WIDTH  byte address, port p at slice p
port_we_i  in  NUM_PORTS  write enable
port_be_i  in  NUM_PORTS*IN_WIDTH/8  byte enables
port_wdata_i  in  NUM_PORTS*IN_WIDTH  write data
port_rdata_o  out  NUM_PORTS*IN_WIDTH  read data, lane-extracted
ram_en_o  out  1  RAM access strobe
ram_addr_o  out  ADDR_WIDTH  RAM byte address
ram_we_o  out  1  RAM write enable
ram_be_o  out  OUT_WIDTH/8  RAM byte enables
ram_wdata_o  out  OUT_WIDTH  RAM write data
ram_rdata_i  in  OUT_WIDTH  RAM read data
stall_cnt_o  out  NUM_PORTS*16  per-port stall counters (optional feature)

Behaviour:
- One clock (clk). Reset rst_n is synchronous, active-low. All state clears on the first clk edge with rst_n=0.

Arbitration:
- At most one grant per cycle. Grant is combinational from port_req_i and the pointer rr_q.
- ARB_MODE=1: grant the first requesting port scanning p = rr_q, rr_q+1, … modulo NUM_PORTS.
  - After a grant to k: rr_q <= (k+1) mod NUM_PORTS.
  - No request: rr_q holds.
  - rr_q resets to 0.
- ARB_MODE=0: lowest-index requester wins; rr_q is unused.
- A requester must hold req and its fields stable until granted. A granted port may re-request back-to-back.

RAM drive:
- ram_en_o = OR of port_req_i.
- Address, we, be and wdata come from the granted port.
- With no grant, ram_addr_o, ram_we_o, ram_be_o and ram_wdata_o are all 0.

Lane steering (only when IN_WIDTH < OUT_WIDTH):
- lane = addr[clog2(OUT_WIDTH/8)-1 : clog2(IN_WIDTH/8)].
- ram_be_o places port_be_i at lane; all other bytes are 0.
- ram_wdata_o is port_wdata_i replicated OUT_WIDTH/IN_WIDTH times.
- When IN_WIDTH == OUT_WIDTH: pass-through, no lane logic.

Response pipeline:
- RAM_LATENCY stages, each holding {valid, port id, lane}. Stage 0 loads {grant_any, granted id, lane} every cycle.
- port_rvalid_o[id] = last-stage valid. This applies to reads and writes alike.
- Latency from grant to rvalid is exactly RAM_LATENCY cycles.
- Pipeline accepts one grant per cycle. Responses return in grant order, so full throughput has no bubbles.

Read data:
- port_rdata_o[p] = ram_rdata_i lane slice selected by the lane last delivered to port p.
- Per-port lane register updates only on that port's rvalid. Data is meaningful only while rvalid is high.

Reset and outputs:
- Reset mid-operation: all pipeline valid bits cleared. No rvalid is issued for accesses granted before reset.
- Output reset values: port_rvalid_o = 0, stall_cnt_o = 0.
- Combinational outputs with all req low: port_gnt_o = 0, ram_en_o = 0.

Optional Feature:
- Macro RAM_ARB_STALL_CNT_EN.
- Defined: per-port 16-bit counter increments each cycle port_req_i[p]=1 && port_gnt_o[p]=0. It saturates at 0xFFFF and clears on reset. Counters drive stall_cnt_o.
- Not defined: no counter logic; stall_cnt_o tied to 0.

Test Plan:
- Config NUM_PORTS=4, IN=32, OUT=32, LAT=1, RR. Ports 0..3 all request continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3; each rvalid one cycle after its grant.
- Same config, ARB_MODE=0. Ports 1 and 2 request for 3 cycles -> port 1 granted all 3 cycles, port 2 never; with RAM_ARB_STALL_CNT_EN, stall_cnt_o[2]=3.
- IN=8, OUT=32. Port 0 writes 0xA5, be=1, addr=0x102 -> ram_be_o=0b0100, ram_wdata_o=0xA5A5A5A5, ram_addr_o=0x102. Port 0 then reads 0x103 with ram_rdata_i=0x11223344 -> port_rdata_o[0]=0x11.
- LAT=3. Port 2 reads at cycle 0, port 3 at cycle 1 -> port_rvalid_o[2] at cycle 3, port_rvalid_o[3] at cycle 4; no other rvalid.
- LAT=2. rst_n driven low for one cycle immediately after a grant -> no rvalid ever issued for it; rr_q restarts at 0, so the next concurrent request on ports 1 and 0 grants port 0.
- Stall counter saturation: port 1 blocked by continuous port 0 traffic (fixed priority) for 70000 cycles -> stall_cnt_o[1]=0xFFFF and stays there.
